// File: rtl/counter_pkg.sv
// Shared types for the mode counter: run-mode and state encodings.
package counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

endpackage

// File: rtl/counter_prescaler.sv
// Step-rate prescaler: asserts tick once every presc+1 enabled cycles.
module counter_prescaler #(
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               clr,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] p_reg;
   logic               hit;

   // Compared against the live presc, so a new divide value applies at the next compare.
   assign hit  = (p_reg == presc);
   assign tick = enable && hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_reg <= '0;
      end else if (clr) begin
         p_reg <= '0;
      end else if (enable) begin
         p_reg <= hit ? '0 : p_reg + 1'b1;
      end
   end

endmodule

// File: rtl/mode_counter.sv
// Up/down counter with programmable limit, wrap/saturate/one-shot modes,
// prescaled stepping, terminal-count pulse, done level and sticky wrap flag.
module mode_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_value,
   input  logic               direction,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   limit,
   input  logic [PRESC_W-1:0] presc,
   input  logic               clear_flags,
   output logic [WIDTH-1:0]   count,
   output logic               tc,
   output logic               done,
   output logic               wrapped
);

   mode_t            mode_sel;
   state_t           state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic             tc_reg, tc_next;
   logic             wrapped_reg, wrapped_next;
   logic             tick;
   logic             at_term;
   logic             wrap_event;

   assign mode_sel = mode_t'(mode);

   counter_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .clr    (load),
      .presc  (presc),
      .tick   (tick)
   );

   // Up uses >= so a count loaded or left above the limit still terminates.
   assign at_term = direction ? (count_reg >= limit) : (count_reg == '0);

   always_comb begin
      count_next   = count_reg;
      tc_next      = 1'b0;
      state_next   = state_reg;
      wrapped_next = wrapped_reg;
      wrap_event   = 1'b0;

      if (load) begin
         count_next = load_value;
         state_next = ST_RUN;
      end else if (tick && (state_reg == ST_RUN)) begin
         if (!at_term) begin
            count_next = direction ? count_reg + 1'b1 : count_reg - 1'b1;
         end else begin
            tc_next = 1'b1;
            case (mode_sel)
               MODE_SAT:     count_next = count_reg;
               MODE_ONESHOT: state_next = ST_DONE;
               default: begin
                  wrap_event = 1'b1;
                  count_next = direction ? '0 : limit;
               end
            endcase
         end
      end

      if (wrap_event) begin
         wrapped_next = 1'b1;
      end else if (clear_flags) begin
         wrapped_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_RUN;
         count_reg   <= '0;
         tc_reg      <= 1'b0;
         wrapped_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         tc_reg      <= tc_next;
         wrapped_reg <= wrapped_next;
      end
   end

   assign count   = count_reg;
   assign tc      = tc_reg;
   assign done    = (state_reg == ST_DONE);
   assign wrapped = wrapped_reg;

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter: expectations are queued as stimulus is
// driven and popped one cycle later when the registered outputs appear.
module tb_mode_counter;

   localparam int WIDTH   = 8;
   localparam int PRESC_W = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               enable = 1'b0;
   logic               load = 1'b0;
   logic [WIDTH-1:0]   load_value = '0;
   logic               direction = 1'b0;
   logic [1:0]         mode = 2'b00;
   logic [WIDTH-1:0]   limit = '0;
   logic [PRESC_W-1:0] presc = '0;
   logic               clear_flags = 1'b0;
   logic [WIDTH-1:0]   count;
   logic               tc;
   logic               done;
   logic               wrapped;

   typedef struct packed {
      logic [WIDTH-1:0] count;
      logic             tc;
      logic             done;
      logic             wrapped;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mode_counter #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .load        (load),
      .load_value  (load_value),
      .direction   (direction),
      .mode        (mode),
      .limit       (limit),
      .presc       (presc),
      .clear_flags (clear_flags),
      .count       (count),
      .tc          (tc),
      .done        (done),
      .wrapped     (wrapped)
   );

   task automatic push(input int c, input bit t, input bit d, input bit w);
      exp_t x;
      x.count   = c[WIDTH-1:0];
      x.tc      = t;
      x.done    = d;
      x.wrapped = w;
      sb.push_back(x);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      push(0, 0, 0, 0);
      e = sb.pop_front();
      checks++;
      if ({count, tc, done, wrapped} !== e) begin
         errors++;
         $display("FAIL reset: count=%0d tc=%b done=%b wrapped=%b, want count=%0d tc=%b done=%b wrapped=%b",
                  count, tc, done, wrapped, e.count, e.tc, e.done, e.wrapped);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_wrap_up();
      limit = 8'd5; mode = 2'b00; direction = 1'b1; presc = '0; enable = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         push((i < 6) ? i : 0, i == 6, 0, i == 6);
         advance();
         e = sb.pop_front();
         checks++;
         if ({count, tc, done, wrapped} !== e) begin
            errors++;
            $display("FAIL wrap_up step %0d: count=%0d tc=%b done=%b wrapped=%b, want count=%0d tc=%b done=%b wrapped=%b",
                     i, count, tc, done, wrapped, e.count, e.tc, e.done, e.wrapped);
         end
         $display("wrap_up step %0d: count=%0d tc=%b wrapped=%b", i, count, tc, wrapped);
      end
   endtask

   task automatic test_sat_down();
      mode = 2'b01; direction = 1'b0;
      for (int i = 0; i < 5; i++) begin
         load        = (i == 0);
         load_value  = 8'd2;
         clear_flags = (i == 0);
         enable      = (i != 0);
         if (i == 0) push(2, 0, 0, 0);
         else        push((i == 1) ? 1 : 0, i >= 3, 0, 0);
         advance();
         e = sb.pop_front();
         checks++;
         if ({count, tc, done, wrapped} !== e) begin
            errors++;
            $display("FAIL sat_down step %0d: count=%0d tc=%b done=%b wrapped=%b, want count=%0d tc=%b done=%b wrapped=%b",
                     i, count, tc, done, wrapped, e.count, e.tc, e.done, e.wrapped);
         end
         $display("sat_down step %0d: count=%0d tc=%b", i, count, tc);
      end
      load = 1'b0; clear_flags = 1'b0;
   endtask

   task automatic test_oneshot();
      mode = 2'b10; direction = 1'b1; presc = 4'd2; limit = 8'd3; enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         load       = (i == 0) || (i == 16);
         load_value = (i == 0) ? 8'd0 : 8'd1;
         if (i == 0)       push(0, 0, 0, 0);
         else if (i <= 15) push(((i / 3) > 3) ? 3 : (i / 3), i == 12, i >= 12, 0);
         else              push((i == 19) ? 2 : 1, 0, 0, 0);
         advance();
         e = sb.pop_front();
         checks++;
         if ({count, tc, done, wrapped} !== e) begin
            errors++;
            $display("FAIL oneshot step %0d: count=%0d tc=%b done=%b wrapped=%b, want count=%0d tc=%b done=%b wrapped=%b",
                     i, count, tc, done, wrapped, e.count, e.tc, e.done, e.wrapped);
         end
         $display("oneshot step %0d: count=%0d tc=%b done=%b", i, count, tc, done);
      end
      load = 1'b0;
   endtask

   task automatic test_load_above_limit();
      mode = 2'b00; direction = 1'b1; presc = '0; limit = 8'd10; enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         load       = (i == 0) || (i == 2);
         load_value = 8'd200;
         if (i == 2) direction = 1'b0;
         case (i)
            0:       push(200, 0, 0, 0);
            1:       push(0, 1, 0, 1);
            2:       push(200, 0, 0, 1);
            3:       push(199, 0, 0, 1);
            default: push(198, 0, 0, 1);
         endcase
         advance();
         e = sb.pop_front();
         checks++;
         if ({count, tc, done, wrapped} !== e) begin
            errors++;
            $display("FAIL load_above step %0d: count=%0d tc=%b done=%b wrapped=%b, want count=%0d tc=%b done=%b wrapped=%b",
                     i, count, tc, done, wrapped, e.count, e.tc, e.done, e.wrapped);
         end
         $display("load_above step %0d: count=%0d tc=%b wrapped=%b", i, count, tc, wrapped);
      end
      load = 1'b0;
   endtask

   task automatic test_simultaneous();
      mode = 2'b00; direction = 1'b1; presc = '0; limit = 8'd100; enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         load        = (i == 0) || (i == 2) || (i == 5);
         load_value  = (i == 0) ? 8'd50 : 8'd100;
         clear_flags = (i == 2) || (i == 3);
         if (i == 5) mode = 2'b11;
         case (i)
            0:       push(50, 0, 0, 1);
            1:       push(51, 0, 0, 1);
            2:       push(100, 0, 0, 0);
            3:       push(0, 1, 0, 1);
            4:       push(1, 0, 0, 1);
            5:       push(100, 0, 0, 1);
            default: push(0, 1, 0, 1);
         endcase
         advance();
         e = sb.pop_front();
         checks++;
         if ({count, tc, done, wrapped} !== e) begin
            errors++;
            $display("FAIL simultaneous step %0d: count=%0d tc=%b done=%b wrapped=%b, want count=%0d tc=%b done=%b wrapped=%b",
                     i, count, tc, done, wrapped, e.count, e.tc, e.done, e.wrapped);
         end
         $display("simultaneous step %0d: count=%0d tc=%b wrapped=%b", i, count, tc, wrapped);
      end
      load = 1'b0; clear_flags = 1'b0;
   endtask

   task automatic test_async_reset();
      mode = 2'b10; direction = 1'b1; presc = '0; limit = 8'd7; enable = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         load       = (i == 0);
         load_value = 8'd0;
         if (i == 0)     push(0, 0, 0, 1);
         else if (i < 8) push(i, 0, 0, 1);
         else            push(7, 1, 1, 1);
         advance();
         e = sb.pop_front();
         checks++;
         if ({count, tc, done, wrapped} !== e) begin
            errors++;
            $display("FAIL async_reset pre step %0d: count=%0d tc=%b done=%b wrapped=%b, want count=%0d tc=%b done=%b wrapped=%b",
                     i, count, tc, done, wrapped, e.count, e.tc, e.done, e.wrapped);
         end
      end
      load = 1'b0;
      // Assert reset between clock edges; outputs must clear without an edge.
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         push(0, 0, 0, 0);
         e = sb.pop_front();
         checks++;
         if ({count, tc, done, wrapped} !== e) begin
            errors++;
            $display("FAIL async_reset held %0d: count=%0d tc=%b done=%b wrapped=%b, want all zero",
                     i, count, tc, done, wrapped);
         end
         $display("async_reset held %0d: count=%0d tc=%b done=%b wrapped=%b", i, count, tc, done, wrapped);
         if (i == 0) advance();
      end
      mode = 2'b00; limit = 8'd5;
      #3 rst_n = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         push(i, 0, 0, 0);
         advance();
         e = sb.pop_front();
         checks++;
         if ({count, tc, done, wrapped} !== e) begin
            errors++;
            $display("FAIL async_reset resume %0d: count=%0d tc=%b done=%b wrapped=%b, want count=%0d tc=%b done=%b wrapped=%b",
                     i, count, tc, done, wrapped, e.count, e.tc, e.done, e.wrapped);
         end
         $display("async_reset resume %0d: count=%0d", i, count);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_wrap_up();
      test_sat_down();
      test_oneshot();
      test_load_above_limit();
      test_simultaneous();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
